// File: rtl/ex_pkg.sv
// ex_pkg: shared widths, stall encoding, ALU op bit positions, divider state
// type and the packed layout of the ID->EX bus for the EX stage.
package ex_pkg;

  localparam int ID_TO_EX_WD  = 159;
  localparam int EX_TO_MEM_WD = 76;
  localparam int EX_TO_ID_WD  = 38;
  localparam int STALL_BUS_WD = 6;
  localparam int HILO_WD      = 65;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  // Bit positions inside the one-hot 12-bit alu_op.
  localparam int ALU_ADD  = 11;
  localparam int ALU_SUB  = 10;
  localparam int ALU_SLT  = 9;
  localparam int ALU_SLTU = 8;
  localparam int ALU_AND  = 7;
  localparam int ALU_NOR  = 6;
  localparam int ALU_OR   = 5;
  localparam int ALU_XOR  = 4;
  localparam int ALU_SLL  = 3;
  localparam int ALU_SRL  = 2;
  localparam int ALU_SRA  = 1;
  localparam int ALU_LUI  = 0;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] FUNC_DIV   = 6'h1A;
  localparam logic [5:0] FUNC_DIVU  = 6'h1B;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_DONE = 2'd2
  } div_state_t;

  // Field order matches the flat ID->EX bus, msb first.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [11:0] alu_op;
    logic [2:0]  sel_alu_src1;
    logic [3:0]  sel_alu_src2;
    logic        data_ram_en;
    logic [3:0]  data_ram_wen;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic        sel_rf_res;
    logic [31:0] rdata1;
    logic [31:0] rdata2;
  } id_to_ex_t;

  // Magnitude of v when treated as signed (take=1), otherwise v unchanged.
  function automatic logic [31:0] abs32(input logic [31:0] v, input logic take);
    return (take && v[31]) ? -v : v;
  endfunction

endpackage

// File: rtl/ex_alu.sv
// ex_alu: combinational ALU driven by a one-hot 12-bit operation vector.
// Ports: alu_op (one-hot op select), src1/src2 (operands), result.
// Shift amounts come from src1[4:0]; LUI places src2[15:0] in the top half.
module ex_alu
  import ex_pkg::*;
(
  input  logic [11:0] alu_op,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  output logic [31:0] result
);

  always_comb begin
    result = '0;
    if (alu_op[ALU_ADD])  result = result | (src1 + src2);
    if (alu_op[ALU_SUB])  result = result | (src1 - src2);
    if (alu_op[ALU_SLT])  result = result | {31'b0, $signed(src1) < $signed(src2)};
    if (alu_op[ALU_SLTU]) result = result | {31'b0, src1 < src2};
    if (alu_op[ALU_AND])  result = result | (src1 & src2);
    if (alu_op[ALU_NOR])  result = result | ~(src1 | src2);
    if (alu_op[ALU_OR])   result = result | (src1 | src2);
    if (alu_op[ALU_XOR])  result = result | (src1 ^ src2);
    if (alu_op[ALU_SLL])  result = result | (src2 << src1[4:0]);
    if (alu_op[ALU_SRL])  result = result | (src2 >> src1[4:0]);
    if (alu_op[ALU_SRA])  result = result | $unsigned($signed(src2) >>> src1[4:0]);
    if (alu_op[ALU_LUI])  result = result | {src2[15:0], 16'b0};
  end

endmodule

// File: rtl/ex.sv
// ex: execute stage. Registers the ID->EX bus, runs the ALU, drives the data
// SRAM request, forwards results to ID, and runs a multi-cycle radix-2
// restoring divider for DIV/DIVU that writes HI/LO via hilo_bus.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   stall                per-stage stop vector (bit2 = ID, bit3 = EX, 1 = stop)
//   id_to_ex_bus         decoded instruction from ID (layout: id_to_ex_t)
//   ex_to_mem_bus        {pc, data_ram_en, data_ram_wen, sel_rf_res, rf_we, rf_waddr, ex_result}
//   ex_to_id_bus         forwarding {rf_we, rf_waddr, ex_result}
//   hilo_bus             {hilo_we, hi, lo}, valid for one cycle when a division completes
//   data_sram_*          data memory request
//   inst_is_load         the instruction in EX is a load
//   stallreq_for_ex      EX needs more cycles (division in progress)
// Stall semantics: stallreq_for_ex asks the stall controller to freeze EX and
// earlier stages; the stage register only changes when stall[2] or stall[3]
// is released, and a stopped ID with a running EX inserts a bubble.
module ex
  import ex_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [STALL_BUS_WD-1:0] stall,
  input  logic [ID_TO_EX_WD-1:0]  id_to_ex_bus,
  output logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  output logic [EX_TO_ID_WD-1:0]  ex_to_id_bus,
  output logic [HILO_WD-1:0]      hilo_bus,
  output logic                    data_sram_en,
  output logic [3:0]              data_sram_wen,
  output logic [31:0]             data_sram_addr,
  output logic [31:0]             data_sram_wdata,
  output logic                    inst_is_load,
  output logic                    stallreq_for_ex
);

  id_to_ex_t stage_r;
  logic      stage_load;

  assign stage_load = (stall[2] == NO_STOP) || (stall[3] == NO_STOP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_r <= '0;
    end else if (stall[2] == NO_STOP) begin
      stage_r <= id_to_ex_t'(id_to_ex_bus);
    end else if (stall[3] == NO_STOP) begin
      stage_r <= '0;
    end
  end

  // ALU operand selection (one-hot selects).
  logic [31:0] src1, src2, imm_sext, imm_zext, ex_result;

  assign imm_sext = {{16{stage_r.inst[15]}}, stage_r.inst[15:0]};
  assign imm_zext = {16'b0, stage_r.inst[15:0]};

  assign src1 = ({32{stage_r.sel_alu_src1[0]}} & stage_r.rdata1)
              | ({32{stage_r.sel_alu_src1[1]}} & stage_r.pc)
              | ({32{stage_r.sel_alu_src1[2]}} & {27'b0, stage_r.inst[10:6]});

  assign src2 = ({32{stage_r.sel_alu_src2[0]}} & stage_r.rdata2)
              | ({32{stage_r.sel_alu_src2[1]}} & imm_sext)
              | ({32{stage_r.sel_alu_src2[2]}} & 32'd8)
              | ({32{stage_r.sel_alu_src2[3]}} & imm_zext);

  ex_alu u_alu (
    .alu_op (stage_r.alu_op),
    .src1   (src1),
    .src2   (src2),
    .result (ex_result)
  );

  assign ex_to_mem_bus = {stage_r.pc, stage_r.data_ram_en, stage_r.data_ram_wen,
                          stage_r.sel_rf_res, stage_r.rf_we, stage_r.rf_waddr, ex_result};
  assign ex_to_id_bus  = {stage_r.rf_we, stage_r.rf_waddr, ex_result};

  assign data_sram_en    = stage_r.data_ram_en;
  assign data_sram_wen   = stage_r.data_ram_wen;
  assign data_sram_addr  = ex_result;
  assign data_sram_wdata = stage_r.rdata2;
  assign inst_is_load    = stage_r.data_ram_en && (stage_r.data_ram_wen == 4'b0000);

  // Divider
  logic is_div, is_divu, div_op, div_req, div_done_r;

  assign is_div  = (stage_r.inst[31:26] == OP_SPECIAL) && (stage_r.inst[5:0] == FUNC_DIV);
  assign is_divu = (stage_r.inst[31:26] == OP_SPECIAL) && (stage_r.inst[5:0] == FUNC_DIVU);
  assign div_op  = is_div || is_divu;
  // div_done_r marks that the instruction still sitting in EX has already
  // produced its HI/LO result, so a held stage cannot start it a second time.
  assign div_req = div_op && !div_done_r;

  div_state_t  div_state, div_state_nxt;
  logic [4:0]  div_cnt;
  logic [31:0] rem_r, quo_r, dvs_r;
  logic        neg_q_r, neg_r_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) div_state <= DIV_IDLE;
    else        div_state <= div_state_nxt;
  end

  always_comb begin
    div_state_nxt   = div_state;
    stallreq_for_ex = 1'b0;
    case (div_state)
      DIV_IDLE: begin
        if (div_req) begin
          stallreq_for_ex = 1'b1;
          div_state_nxt   = (stage_r.rdata2 == 32'd0) ? DIV_DONE : DIV_RUN;
        end
      end
      DIV_RUN: begin
        stallreq_for_ex = div_op;
        if (div_cnt == 5'd31) div_state_nxt = DIV_DONE;
      end
      DIV_DONE: div_state_nxt = DIV_IDLE;
      default:  div_state_nxt = DIV_IDLE;
    endcase
  end

  // One restoring step: shift the next dividend bit into the partial
  // remainder and subtract the divisor if it fits.
  logic [32:0] shifted;
  logic [33:0] diff;
  logic        step_bit;
  logic [31:0] step_rem;

  assign shifted  = {rem_r, quo_r[31]};
  assign diff     = {1'b0, shifted} - {2'b0, dvs_r};
  assign step_bit = ~diff[33];
  assign step_rem = step_bit ? diff[31:0] : shifted[31:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt    <= '0;
      rem_r      <= '0;
      quo_r      <= '0;
      dvs_r      <= '0;
      neg_q_r    <= 1'b0;
      neg_r_r    <= 1'b0;
      div_done_r <= 1'b0;
    end else begin
      // A newly loaded instruction (or bubble) always clears the marker, even
      // on the same edge that leaves DONE.
      if (stage_load)                 div_done_r <= 1'b0;
      else if (div_state == DIV_DONE) div_done_r <= 1'b1;

      case (div_state)
        DIV_IDLE: begin
          if (div_req) begin
            div_cnt <= '0;
            if (stage_r.rdata2 == 32'd0) begin
              quo_r   <= '1;
              rem_r   <= stage_r.rdata1;
              neg_q_r <= 1'b0;
              neg_r_r <= 1'b0;
            end else begin
              quo_r   <= abs32(stage_r.rdata1, is_div);
              rem_r   <= '0;
              dvs_r   <= abs32(stage_r.rdata2, is_div);
              neg_q_r <= is_div && (stage_r.rdata1[31] ^ stage_r.rdata2[31]);
              neg_r_r <= is_div && stage_r.rdata1[31];
            end
          end
        end
        DIV_RUN: begin
          rem_r   <= step_rem;
          quo_r   <= {quo_r[30:0], step_bit};
          div_cnt <= div_cnt + 5'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    hilo_bus = '0;
    if (div_state == DIV_DONE) begin
      hilo_bus = {1'b1, (neg_r_r ? -rem_r : rem_r), (neg_q_r ? -quo_r : quo_r)};
    end
  end

  logic unused_bits;
  assign unused_bits = ^{stall[5:4], stall[1:0], stage_r.inst[25:16], diff[32]};

endmodule

// File: doc/ex.md
EX -- requirements
Module: ex

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-003 SHALL have port stall, input, StallBus (6 bits): pipeline stall vector; Stop=1; bit2=ID, bit3=EX.
REQ-004 SHALL have port id_to_ex_bus, input, ID_TO_EX_WD (159 bits): {pc[158:127], inst[126:95], alu_op[94:83], sel_alu_src1[82:80], sel_alu_src2[79:76], data_ram_en[75], data_ram_wen[74:71], rf_we[70], rf_waddr[69:65], sel_rf_res[64], rdata1[63:32], rdata2[31:0]}.
REQ-005 SHALL have port ex_to_mem_bus, output, EX_TO_MEM_WD (76 bits): {pc, data_ram_en, data_ram_wen, sel_rf_res, rf_we, rf_waddr, ex_result}.
REQ-006 SHALL have port ex_to_id_bus, output, EX_TO_ID_WD (38 bits): forwarding {rf_we[37], rf_waddr[36:32], ex_result[31:0]}.
REQ-007 SHALL have port hilo_bus, output, 65 bits: {hilo_we, hi, lo} from the divider.
REQ-008 SHALL have ports data_sram_en (1 bit), data_sram_wen (4 bits), data_sram_addr (32 bits), data_sram_wdata (32 bits), all outputs.
REQ-009 SHALL have ports inst_is_load (1 bit) and stallreq_for_ex (1 bit), both outputs.

Function
REQ-010 SHALL load id_to_ex_bus into the stage register when stall[2]=NoStop; SHALL load zero (bubble) when stall[2]=Stop and stall[3]=NoStop; SHALL otherwise hold.
REQ-011 SHALL form ALU src1 one-hot: rdata1 / pc / zero-extended inst[10:6]; src2 one-hot: rdata2 / sign-extended imm / 32'd8 / zero-extended imm.
REQ-012 SHALL compute ex_result combinationally via the alu sub-module from the 12-bit alu_op, in the same cycle as the instruction occupies the stage.
REQ-013 SHALL drive data_sram_en=data_ram_en, data_sram_wen=data_ram_wen, data_sram_addr=ex_result, data_sram_wdata=rdata2.
REQ-014 SHALL drive inst_is_load=1 iff data_ram_en=1 and data_ram_wen=4'b0000.
REQ-015 SHALL decode DIV (opcode 0, func 6'h1A) and DIVU (opcode 0, func 6'h1B) from the registered inst.
REQ-016 SHALL run a radix-2 restoring divider FSM with states IDLE, RUN, DONE; IDLE->RUN on a div instruction with nonzero divisor (rdata2); RUN iterates exactly 32 cycles; RUN->DONE after the 32nd iteration; DONE->IDLE after one cycle.
REQ-017 SHALL, for DIV, divide magnitudes, then negate the quotient if operand signs differ and give the remainder the dividend's sign.
REQ-018 SHALL, for divisor 0, go IDLE->DONE directly with lo=32'hFFFF_FFFF and hi=dividend.
REQ-019 SHALL assert stallreq_for_ex while a div instruction is in the stage and the FSM is in IDLE or RUN; SHALL deassert it in DONE.
REQ-020 SHALL assert hilo_we only during DONE, with hi=remainder and lo=quotient; zero otherwise.
REQ-021 SHALL, once in DONE, not restart on the same instruction, even if stall[3] stays Stop for further cycles due to a later-stage stall.
REQ-022 SHALL leave non-div instructions single-cycle, with stallreq_for_ex=0.

Reset
REQ-023 SHALL, on rst_n=0 (at any time, including mid-division), clear the stage register, FSM (to IDLE), counter and divider datapath; all outputs are then 0.

Structure
REQ-024 SHALL take ID_TO_EX_WD, EX_TO_MEM_WD, EX_TO_ID_WD, StallBus, Stop/NoStop from lib/defines.vh, adding HILO_WD=65 there.
REQ-025 SHALL instantiate the existing alu as its only sub-module; the divider FSM is inline.

Verification
REQ-026 Reset release, then ADDU rdata1=5, rdata2=7 -> ex_result=12, rf_we=1, stallreq_for_ex=0.
REQ-027 LW with rdata1=0x1000, imm=4 -> data_sram_addr=0x1004, data_sram_en=1, wen=0, inst_is_load=1.
REQ-028 DIV -7/2 -> stallreq_for_ex high 33 cycles; DONE gives lo=0xFFFF_FFFD, hi=0xFFFF_FFFF, hilo_we=1 for one cycle.
REQ-029 DIVU 0xFFFF_FFFF/0 -> one-cycle stall; then lo=0xFFFF_FFFF, hi=0xFFFF_FFFF.
REQ-030 rst_n low at RUN iteration 10 -> FSM IDLE, outputs zero; no hilo_we after release.
REQ-031 stall[2]=1, stall[3]=0 -> next cycle stage holds a bubble: rf_we=0, data_sram_en=0.
